// File: rtl/accuracy_counter.sv
// Scores each two-class prediction against its label, counts hits over ROWS
// samples, then derives floor(hits*100/ROWS) with a 7-step restoring divider.
module accuracy_counter #(
  parameter int ROWS = 100,
  parameter int CW   = $clog2(ROWS+1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [63:0]   score0,
  input  logic [63:0]   score1,
  input  logic [63:0]   label,
  output logic          pred_valid,
  output logic          pred_class,
  output logic          pred_correct,
  output logic [CW-1:0] correct_count,
  output logic [CW-1:0] total_count,
  output logic [6:0]    acc_pct,
  output logic          acc_cal
);

  // Wide enough for the dividend (<= ROWS*100) and the divisor shifted by 6.
  localparam int DW = $clog2(ROWS*128+1);

  typedef enum logic [1:0] {ACCEPT, DIVIDE, DONE} state_e;

  typedef struct packed {
    logic vld;
    logic cls;
    logic cor;
  } pred_t;

  state_e          state_q, state_d;
  pred_t           pred_q, pred_d;
  logic [CW-1:0]   correct_q, correct_d;
  logic [CW-1:0]   total_q, total_d;
  logic [DW-1:0]   rem_q, rem_d;
  logic [5:0]      quo_q, quo_d;
  logic [2:0]      div_cnt_q, div_cnt_d;
  logic [6:0]      acc_pct_q, acc_pct_d;
  logic            acc_cal_q, acc_cal_d;

  logic            hs, cls, lab_cls, qbit;
  logic [DW-1:0]   sub;

  // IEEE-754 a > b; NaN on either side and +0/-0 pairs never compare greater.
  function automatic logic f64_gt(input logic [63:0] a, input logic [63:0] b);
    logic a_nan, b_nan;
    a_nan = (a[62:52] == 11'h7FF) && (a[51:0] != 52'd0);
    b_nan = (b[62:52] == 11'h7FF) && (b[51:0] != 52'd0);
    if (a_nan || b_nan) return 1'b0;
    if ((a[62:0] == 63'd0) && (b[62:0] == 63'd0)) return 1'b0;
    if (a[63] != b[63]) return !a[63];
    if (!a[63]) return a[62:0] > b[62:0];
    return a[62:0] < b[62:0];
  endfunction

  assign in_ready = rst_n && (state_q == ACCEPT);
  assign hs       = in_valid && in_ready;
  assign cls      = f64_gt(score1, score0);
  assign lab_cls  = (label & 64'h7FFF_FFFF_FFFF_FFFF) != 64'd0;
  assign sub      = DW'(ROWS) << div_cnt_q;
  assign qbit     = rem_q >= sub;

  always_comb begin
    state_d   = state_q;
    pred_d    = pred_q;
    pred_d.vld = 1'b0;
    correct_d = correct_q;
    total_d   = total_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    div_cnt_d = div_cnt_q;
    acc_pct_d = acc_pct_q;
    acc_cal_d = acc_cal_q;
    case (state_q)
      ACCEPT: begin
        if (hs) begin
          pred_d.vld = 1'b1;
          pred_d.cls = cls;
          pred_d.cor = (cls == lab_cls);
          total_d    = total_q + 1'b1;
          if (cls == lab_cls) correct_d = correct_q + 1'b1;
          if (total_q == CW'(ROWS-1)) begin
            state_d   = DIVIDE;
            rem_d     = DW'(correct_d) * DW'(100);
            quo_d     = 6'd0;
            div_cnt_d = 3'd6;
          end
        end
      end
      DIVIDE: begin
        if (qbit) rem_d = rem_q - sub;
        quo_d = {quo_q[4:0], qbit};
        if (div_cnt_q == 3'd0) begin
          acc_pct_d = {quo_q, qbit};
          acc_cal_d = 1'b1;
          state_d   = DONE;
        end else begin
          div_cnt_d = div_cnt_q - 3'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ACCEPT;
      pred_q    <= '0;
      correct_q <= '0;
      total_q   <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      div_cnt_q <= '0;
      acc_pct_q <= '0;
      acc_cal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pred_q    <= pred_d;
      correct_q <= correct_d;
      total_q   <= total_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      div_cnt_q <= div_cnt_d;
      acc_pct_q <= acc_pct_d;
      acc_cal_q <= acc_cal_d;
    end
  end

  assign pred_valid    = pred_q.vld;
  assign pred_class    = pred_q.cls;
  assign pred_correct  = pred_q.cor;
  assign correct_count = correct_q;
  assign total_count   = total_q;
  assign acc_pct       = acc_pct_q;
  assign acc_cal       = acc_cal_q;

endmodule

// File: tb/tb_accuracy_counter.sv
// Scoreboard bench: one block at ROWS=100 and one at ROWS=3, directed vectors.
module tb_accuracy_counter;
  localparam logic [63:0] ONE   = 64'h3FF0000000000000;
  localparam logic [63:0] HALF  = 64'h3FE0000000000000;
  localparam logic [63:0] ZERO  = 64'h0;
  localparam logic [63:0] NZERO = 64'h8000000000000000;
  localparam logic [63:0] NEG1  = 64'hBFF0000000000000;
  localparam logic [63:0] NEGH  = 64'hBFE0000000000000;
  localparam logic [63:0] QNAN  = 64'h7FF8000000000000;
  localparam logic [63:0] PINF  = 64'h7FF0000000000000;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        a_valid, a_ready, a_pv, a_pc, a_pcor, a_cal;
  logic [63:0] a_s0, a_s1, a_lab;
  logic [6:0]  a_cc, a_tc, a_pct;
  logic        b_valid, b_ready, b_pv, b_pc, b_pcor, b_cal;
  logic [63:0] b_s0, b_s1, b_lab;
  logic [1:0]  b_cc, b_tc;
  logic [6:0]  b_pct;

  accuracy_counter #(.ROWS(100)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_ready(a_ready),
    .score0(a_s0), .score1(a_s1), .label(a_lab),
    .pred_valid(a_pv), .pred_class(a_pc), .pred_correct(a_pcor),
    .correct_count(a_cc), .total_count(a_tc), .acc_pct(a_pct), .acc_cal(a_cal));

  accuracy_counter #(.ROWS(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_ready(b_ready),
    .score0(b_s0), .score1(b_s1), .label(b_lab),
    .pred_valid(b_pv), .pred_class(b_pc), .pred_correct(b_pcor),
    .correct_count(b_cc), .total_count(b_tc), .acc_pct(b_pct), .acc_cal(b_cal));

  int errors = 0, checks = 0;
  int a_pulses = 0, b_pulses = 0;
  logic [1:0] qa[$], qb[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitors: pop one expected {class, correct} per pred_valid pulse.
  always @(negedge clk) begin
    logic [1:0] e;
    if (a_pv === 1'b1) begin
      a_pulses++;
      if (qa.size() == 0) chk("a_unexpected_pred", 1, 0);
      else begin
        e = qa.pop_front();
        chk("a_pred_class", a_pc, e[1]);
        chk("a_pred_correct", a_pcor, e[0]);
      end
    end
    if (b_pv === 1'b1) begin
      b_pulses++;
      if (qb.size() == 0) chk("b_unexpected_pred", 1, 0);
      else begin
        e = qb.pop_front();
        chk("b_pred_class", b_pc, e[1]);
        chk("b_pred_correct", b_pcor, e[0]);
      end
    end
  end

  // Present one triple and return just after its handshake edge.
  task automatic send(input bit b, input logic [63:0] s0, input logic [63:0] s1,
                      input logic [63:0] lab, input bit ecls, input bit ecor);
    int n = 0;
    @(negedge clk);
    if (b) begin b_valid = 1; b_s0 = s0; b_s1 = s1; b_lab = lab; end
    else   begin a_valid = 1; a_s0 = s0; a_s1 = s1; a_lab = lab; end
    while (((b ? b_ready : a_ready) !== 1'b1) && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      chk("send_timeout", 0, 1);
      a_valid = 0; b_valid = 0;
      return;
    end
    if (b) qb.push_back({ecls, ecor}); else qa.push_back({ecls, ecor});
    @(posedge clk);
    #1;
    a_valid = 0; b_valid = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("rst_a_tc", a_tc, 0);
    chk("rst_a_cc", a_cc, 0);
    chk("rst_a_cal", a_cal, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    #1;
    chk("rst_a_ready", a_ready, 1);
    a_pulses = 0; b_pulses = 0;
  endtask

  task automatic wait_cal(input bit b, input string nm);
    int n = 0;
    while (((b ? b_cal : a_cal) !== 1'b1) && n < 30) begin @(negedge clk); n++; end
    if (n >= 30) chk(nm, 0, 1);
  endtask

  initial begin
    int exp_cc;
    bit cls, lab, seen;
    logic [63:0] s0, s1, l;
    rst_n = 0;
    a_valid = 0; a_s0 = 0; a_s1 = 0; a_lab = 0;
    b_valid = 0; b_s0 = 0; b_s1 = 0; b_lab = 0;
    #1;
    chk("reset_ready_low", a_ready, 0);
    chk("reset_pv", a_pv, 0);
    chk("reset_pct", a_pct, 0);
    chk("reset_cal", a_cal, 0);
    repeat (3) @(negedge clk);
    rst_n = 1;
    #1;
    chk("post_reset_ready", a_ready, 1);
    chk("post_reset_tc", a_tc, 0);

    // 40 samples, then reset mid-ACCEPT
    exp_cc = 0;
    for (int i = 0; i < 40; i++) begin
      cls = i % 2;
      lab = (i % 3 == 0) ? !cls : cls;
      if (cls == lab) exp_cc++;
      send(0, cls ? HALF : ONE, cls ? ONE : HALF, lab ? ONE : ZERO, cls, cls == lab);
    end
    repeat (2) @(negedge clk);
    chk("mid_tc", a_tc, 40);
    chk("mid_cc", a_cc, exp_cc);
    chk("mid_cal", a_cal, 0);
    do_reset();

    // 100 correct class-1 samples, latency of acc_cal
    for (int i = 0; i < 100; i++) send(0, HALF, ONE, ONE, 1, 1);
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk);
      #1;
      if (k == 6) chk("lat_cal_edge6", a_cal, 0);
      if (k == 7) chk("lat_cal_edge7", a_cal, 1);
    end
    chk("full_cc", a_cc, 100);
    chk("full_tc", a_tc, 100);
    chk("full_pct", a_pct, 100);
    chk("full_ready", a_ready, 0);
    @(negedge clk);
    chk("full_pulses", a_pulses, 100);

    // In DONE: in_valid held high for 20 cycles is ignored
    a_valid = 1; seen = 0;
    repeat (20) begin @(negedge clk); if (a_ready !== 1'b0) seen = 1; end
    a_valid = 0;
    chk("done_ready_low", seen, 0);
    chk("done_pulses", a_pulses, 100);
    chk("done_tc", a_tc, 100);
    chk("done_cc", a_cc, 100);
    chk("done_cal", a_cal, 1);

    // 73 matching + 27 mismatching with random gaps, compare corners first
    do_reset();
    for (int i = 0; i < 100; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      case (i)
        0: begin s0 = NZERO; s1 = ZERO; l = NZERO; cls = 0; lab = 0; end
        1: begin s0 = NEG1;  s1 = NEGH; l = ONE;   cls = 1; lab = 1; end
        2: begin s0 = ZERO;  s1 = QNAN; l = ZERO;  cls = 0; lab = 0; end
        3: begin s0 = ONE;   s1 = PINF; l = ONE;   cls = 1; lab = 1; end
        default: begin
          cls = i % 2;
          lab = (i < 73) ? cls : !cls;
          s0 = cls ? HALF : ONE; s1 = cls ? ONE : HALF; l = lab ? ONE : ZERO;
        end
      endcase
      send(0, s0, s1, l, cls, cls == lab);
    end
    wait_cal(0, "mix_cal_timeout");
    chk("mix_tc", a_tc, 100);
    chk("mix_cc", a_cc, 73);
    chk("mix_pct", a_pct, 73);
    chk("mix_pulses", a_pulses, 100);

    // Reset during DIVIDE
    do_reset();
    for (int i = 0; i < 100; i++) send(0, HALF, ONE, ONE, 1, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("div_rst_cal", a_cal, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    seen = 0;
    repeat (12) begin @(negedge clk); if (a_cal !== 1'b0) seen = 1; end
    chk("div_rst_cal_stays_low", seen, 0);
    chk("div_rst_ready", a_ready, 1);
    chk("div_rst_tc", a_tc, 0);

    // ROWS=3: 2 of 3 correct -> 66, then 0 of 3 -> 0
    send(1, HALF, ONE, ONE, 1, 1);
    send(1, ONE, HALF, ZERO, 0, 1);
    send(1, HALF, ONE, ZERO, 1, 0);
    wait_cal(1, "b66_cal_timeout");
    chk("b66_cc", b_cc, 2);
    chk("b66_pct", b_pct, 66);
    do_reset();
    chk("b_rst_cal", b_cal, 0);
    send(1, HALF, ONE, ZERO, 1, 0);
    send(1, ONE, HALF, ONE, 0, 0);
    send(1, NEGH, NEG1, ONE, 0, 0);
    wait_cal(1, "b0_cal_timeout");
    chk("b0_cal", b_cal, 1);
    chk("b0_cc", b_cc, 0);
    chk("b0_pct", b_pct, 0);
    @(negedge clk);
    chk("b0_pulses", b_pulses, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
